// File: rtl/game_pkg.sv
// Shared definitions for the button front end and the game cores:
// controller states, game_mode codes, and default hold times for a 9 MHz CLK_PIX.
package game_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        S1_DOWN  = 3'd1,
        S2_DOWN  = 3'd2,
        COMBO    = 3'd3,
        WAIT_REL = 3'd4
    } state_e;

    localparam logic [1:0] GAME_PONG   = 2'd0;
    localparam logic [1:0] GAME_SNAKE  = 2'd1;
    localparam logic [1:0] GAME_FLAPPY = 2'd2;
    localparam logic [1:0] GAME_PACMAN = 2'd3;

    localparam int NUM_GAMES = 4;

    // 2 s and 1 s at 9 MHz
    localparam int COMBO_HOLD_CYC_DEF = 18_000_000;
    localparam int LONG_PRESS_CYC_DEF = 9_000_000;

    // Advance to the next game, wrapping from the last one back to Pong.
    function automatic logic [1:0] next_mode(input logic [1:0] mode);
        if (int'(mode) == NUM_GAMES - 1) begin
            return GAME_PONG;
        end
        return mode + 2'd1;
    endfunction

    // One-hot enable vector for the game cores.
    function automatic logic [NUM_GAMES-1:0] mode_onehot(input logic [1:0] mode);
        logic [NUM_GAMES-1:0] oh;
        oh       = '0;
        oh[mode] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/input_mode_ctrl_if.sv
// Bundle between the debouncers / game cores and input_mode_ctrl.
// master = the side that owns the buttons and consumes the controller outputs,
// slave  = the controller itself.
interface input_mode_ctrl_if;

    logic       btn_s1;
    logic       btn_s2;
    logic       s1_level;
    logic       s2_level;
    logic       s1_tap;
    logic       s2_tap;
    logic       game_reset;
    logic       mode_change;
    logic [1:0] game_mode;
    logic [3:0] game_active;
    logic [5:0] led;

    modport master (
        output btn_s1, btn_s2,
        input  s1_level, s2_level, s1_tap, s2_tap,
        input  game_reset, mode_change, game_mode, game_active, led
    );

    modport slave (
        input  btn_s1, btn_s2,
        output s1_level, s2_level, s1_tap, s2_tap,
        output game_reset, mode_change, game_mode, game_active, led
    );

endinterface

// File: rtl/input_mode_ctrl.sv
// Two-button input controller: turns debounced S1/S2 levels into per-game
// button levels, tap pulses, a long-press restart and a two-button mode switch.
// Optional build macro COMBO_PROGRESS_EN: show combo-hold progress as a
// thermometer on led[5:2] while both buttons are held.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// IDLE     | no button held
// S1_DOWN  | S1 alone held, counting towards long-press restart
// S2_DOWN  | S2 alone held
// COMBO    | both held, counting towards a mode advance
// WAIT_REL | action done or aborted, waiting until both buttons are released
module input_mode_ctrl
    import game_pkg::*;
#(
    parameter int COMBO_HOLD_CYC = COMBO_HOLD_CYC_DEF,
    parameter int LONG_PRESS_CYC = LONG_PRESS_CYC_DEF
) (
    input  logic                CLK_PIX,
    input  logic                sys_rst_n,
    input_mode_ctrl_if.slave    bus
);

    localparam int CW = $clog2(COMBO_HOLD_CYC + 1);

    // The count is compared one step early so the action fires on the edge
    // where cnt would reach its terminal value (N-th held cycle).
    localparam logic [CW-1:0] LONG_LAST  = CW'(LONG_PRESS_CYC - 2);
    localparam logic [CW-1:0] COMBO_LAST = CW'(COMBO_HOLD_CYC - 2);

`ifdef COMBO_PROGRESS_EN
    localparam logic [CW-1:0] QTR_1 = CW'(COMBO_HOLD_CYC / 4);
    localparam logic [CW-1:0] QTR_2 = CW'(COMBO_HOLD_CYC / 2);
    localparam logic [CW-1:0] QTR_3 = CW'((3 * COMBO_HOLD_CYC) / 4);
    localparam logic [CW-1:0] QTR_4 = CW'(COMBO_HOLD_CYC - 1);
    logic [3:0] prog_d;
`endif

    state_e               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [1:0]           mode_q, mode_d;
    logic [NUM_GAMES-1:0] active_q, active_d;
    logic [5:0]           led_q, led_d;
    logic                 s1_level_q, s1_level_d;
    logic                 s2_level_q, s2_level_d;
    logic                 s1_tap_q, s1_tap_d;
    logic                 s2_tap_q, s2_tap_d;
    logic                 game_reset_q, game_reset_d;
    logic                 mode_change_q, mode_change_d;

    logic s1, s2;
    assign s1 = bus.btn_s1;
    assign s2 = bus.btn_s2;

    // Next state, shared counter, mode and the registered-output values.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        mode_d        = mode_q;
        s1_tap_d      = 1'b0;
        s2_tap_d      = 1'b0;
        game_reset_d  = 1'b0;
        mode_change_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (s1 && s2) begin
                    state_d = COMBO;
                end else if (s1) begin
                    state_d = S1_DOWN;
                end else if (s2) begin
                    state_d = S2_DOWN;
                end
            end
            S1_DOWN: begin
                if (!s1) begin
                    s1_tap_d = 1'b1;
                    state_d  = IDLE;
                end else if (s2) begin
                    state_d = COMBO;
                end else if (cnt_q == LONG_LAST) begin
                    game_reset_d = 1'b1;
                    state_d      = WAIT_REL;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S2_DOWN: begin
                if (!s2) begin
                    s2_tap_d = 1'b1;
                    state_d  = IDLE;
                end else if (s1) begin
                    state_d = COMBO;
                end
            end
            COMBO: begin
                if (!s1 || !s2) begin
                    state_d = WAIT_REL;
                end else if (cnt_q == COMBO_LAST) begin
                    mode_d        = next_mode(mode_q);
                    mode_change_d = 1'b1;
                    game_reset_d  = 1'b1;
                    state_d       = WAIT_REL;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            WAIT_REL: begin
                if (!s1 && !s2) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (state_d != state_q) begin
            cnt_d = '0;
        end

        s1_level_d = (state_d == S1_DOWN);
        s2_level_d = (state_d == S2_DOWN);
        active_d   = mode_onehot(mode_d);

`ifdef COMBO_PROGRESS_EN
        prog_d = 4'b0000;
        if (state_d == COMBO) begin
            prog_d = {cnt_d >= QTR_4, cnt_d >= QTR_3, cnt_d >= QTR_2, cnt_d >= QTR_1};
        end
        led_d = {prog_d, mode_d};
`else
        led_d = {4'b0000, mode_d};
`endif
    end

    // State, counter and all outputs registered; async active-low reset.
    always_ff @(posedge CLK_PIX or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            mode_q        <= GAME_PONG;
            active_q      <= mode_onehot(GAME_PONG);
            led_q         <= 6'b000000;
            s1_level_q    <= 1'b0;
            s2_level_q    <= 1'b0;
            s1_tap_q      <= 1'b0;
            s2_tap_q      <= 1'b0;
            game_reset_q  <= 1'b0;
            mode_change_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            mode_q        <= mode_d;
            active_q      <= active_d;
            led_q         <= led_d;
            s1_level_q    <= s1_level_d;
            s2_level_q    <= s2_level_d;
            s1_tap_q      <= s1_tap_d;
            s2_tap_q      <= s2_tap_d;
            game_reset_q  <= game_reset_d;
            mode_change_q <= mode_change_d;
        end
    end

    assign bus.s1_level    = s1_level_q;
    assign bus.s2_level    = s2_level_q;
    assign bus.s1_tap      = s1_tap_q;
    assign bus.s2_tap      = s2_tap_q;
    assign bus.game_reset  = game_reset_q;
    assign bus.mode_change = mode_change_q;
    assign bus.game_mode   = mode_q;
    assign bus.game_active = active_q;
    assign bus.led         = led_q;

endmodule

// File: tb/tb_input_mode_ctrl.sv
// Bench for input_mode_ctrl with short hold times (combo 100, long press 40).
// Expected pulses are queued with the cycle they must appear on; a negedge
// monitor pops and compares each pulse the DUT produces.
module tb_input_mode_ctrl;

    localparam int COMBO = 100;
    localparam int LONG  = 40;

    localparam int EV_S1TAP = 1;
    localparam int EV_S2TAP = 2;
    localparam int EV_RESET = 3;
    localparam int EV_MODE  = 4;

    typedef struct {
        int kind;
        int cyc;
        int mode;
    } evt_t;

    logic CLK_PIX;
    logic sys_rst_n;
    int   cyc;
    int   n_checks;
    int   n_err;
    evt_t sb[$];

    input_mode_ctrl_if bus ();

    input_mode_ctrl #(
        .COMBO_HOLD_CYC(COMBO),
        .LONG_PRESS_CYC(LONG)
    ) dut (
        .CLK_PIX  (CLK_PIX),
        .sys_rst_n(sys_rst_n),
        .bus      (bus.slave)
    );

    initial CLK_PIX = 1'b0;
    always #5 CLK_PIX = ~CLK_PIX;

    initial cyc = 0;
    always @(posedge CLK_PIX) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic push_evt(input int kind, input int at, input int mode);
        evt_t e;
        e.kind = kind;
        e.cyc  = at;
        e.mode = mode;
        sb.push_back(e);
    endtask

    task automatic take_evt(input int kind);
        evt_t e;
        check("pulse_pending", (sb.size() > 0) ? 32'd1 : 32'd0, 32'd1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check("pulse_kind", kind, e.kind);
            check("pulse_cycle", cyc, e.cyc);
            if (kind == EV_MODE) begin
                check("mode_on_change", {30'd0, bus.game_mode}, e.mode);
                check("active_on_change", {28'd0, bus.game_active}, 32'd1 << e.mode);
            end
        end
    endtask

    // Pulse monitor: every pulse must match the head of the scoreboard.
    always @(negedge CLK_PIX) begin
        if (bus.s1_tap === 1'b1)      take_evt(EV_S1TAP);
        if (bus.s2_tap === 1'b1)      take_evt(EV_S2TAP);
        if (bus.game_reset === 1'b1)  take_evt(EV_RESET);
        if (bus.mode_change === 1'b1) take_evt(EV_MODE);
    end

    task automatic idle(input int n);
        bus.btn_s1 = 1'b0;
        bus.btn_s2 = 1'b0;
        repeat (n) @(negedge CLK_PIX);
    endtask

    task automatic check_mode(input string tag, input int m);
        check({tag, "_mode"}, {30'd0, bus.game_mode}, m);
        check({tag, "_active"}, {28'd0, bus.game_active}, 32'd1 << m);
        check({tag, "_led"}, {26'd0, bus.led}, m);
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_s1_level"}, {31'd0, bus.s1_level}, 0);
        check({tag, "_s2_level"}, {31'd0, bus.s2_level}, 0);
    endtask

    initial begin
        int c0;
        n_checks   = 0;
        n_err      = 0;
        sys_rst_n  = 1'b0;
        bus.btn_s1 = 1'b0;
        bus.btn_s2 = 1'b0;

        // Reset held 5 cycles, then 10 idle cycles with no pulses.
        repeat (5) @(negedge CLK_PIX);
        check_mode("rst_hold", 0);
        check_quiet("rst_hold");
        sys_rst_n = 1'b1;
        idle(10);
        check_mode("rst_idle", 0);
        check_quiet("rst_idle");

        // Short S1 press: level for 10 cycles, one tap after release.
        c0 = cyc;
        for (int i = 1; i <= 10; i++) begin
            bus.btn_s1 = 1'b1;
            @(negedge CLK_PIX);
            check("tap_s1_level", {31'd0, bus.s1_level}, 1);
        end
        push_evt(EV_S1TAP, c0 + 11, 0);
        bus.btn_s1 = 1'b0;
        @(negedge CLK_PIX);
        check("tap_s1_level_rel", {31'd0, bus.s1_level}, 0);
        idle(4);
        check_mode("tap_s1", 0);

        // Long S1 press: restart at 40th held cycle, no tap on release.
        c0 = cyc;
        push_evt(EV_RESET, c0 + LONG, 0);
        for (int i = 1; i <= 60; i++) begin
            bus.btn_s1 = 1'b1;
            @(negedge CLK_PIX);
            check("long_s1_level", {31'd0, bus.s1_level}, (i < LONG) ? 1 : 0);
        end
        idle(5);
        check_mode("long_s1", 0);

        // Four combo holds of 400 cycles: one advance each, wrap 3 -> 0.
        for (int m = 0; m < 4; m++) begin
            int nm;
            nm = (m + 1) % 4;
            c0 = cyc;
            push_evt(EV_RESET, c0 + COMBO, nm);
            push_evt(EV_MODE, c0 + COMBO, nm);
            bus.btn_s1 = 1'b1;
            bus.btn_s2 = 1'b1;
            repeat (COMBO + 300) @(negedge CLK_PIX);
            check_quiet("combo_hold");
            idle(3);
            check_mode("combo", nm);
        end

        // S2 then S1 joins: combo aborted, no taps, S2 level drops when S1 rises.
        for (int i = 1; i <= 20; i++) begin
            bus.btn_s2 = 1'b1;
            @(negedge CLK_PIX);
            check("s2_level", {31'd0, bus.s2_level}, 1);
        end
        bus.btn_s1 = 1'b1;
        @(negedge CLK_PIX);
        check("s2_level_s1_rise", {31'd0, bus.s2_level}, 0);
        check("s1_level_s1_rise", {31'd0, bus.s1_level}, 0);
        repeat (49) @(negedge CLK_PIX);
        bus.btn_s1 = 1'b0;
        repeat (10) @(negedge CLK_PIX);
        check_quiet("abort_wait");
        idle(4);
        check_mode("abort", 0);

        // Advance to mode 1, then reset mid-combo.
        c0 = cyc;
        push_evt(EV_RESET, c0 + COMBO, 1);
        push_evt(EV_MODE, c0 + COMBO, 1);
        bus.btn_s1 = 1'b1;
        bus.btn_s2 = 1'b1;
        repeat (COMBO) @(negedge CLK_PIX);
        idle(3);
        check_mode("pre_rst", 1);
        bus.btn_s1 = 1'b1;
        bus.btn_s2 = 1'b1;
        repeat (60) @(negedge CLK_PIX);
`ifdef COMBO_PROGRESS_EN
        check("progress_led", {28'd0, bus.led[5:2]}, 32'b0011);
`endif
        sys_rst_n  = 1'b0;
        bus.btn_s2 = 1'b0;
        #1;
        check_mode("mid_rst", 0);
        check_quiet("mid_rst");
        repeat (2) @(negedge CLK_PIX);
        check_mode("mid_rst_hold", 0);

        // S1 still held at reset release counts as a fresh press.
        sys_rst_n = 1'b1;
        @(negedge CLK_PIX);
        check("fresh_s1_level", {31'd0, bus.s1_level}, 1);
        push_evt(EV_S1TAP, cyc + 1, 0);
        bus.btn_s1 = 1'b0;
        idle(5);
        check_mode("end", 0);
        check("sb_empty", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
